// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchroniser plus per-bit stability
// counter. Emits the debounced vector and one-cycle rise/fall pulses.

module sw_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Synchronise, count consecutive disagreeing cycles, accept on the last one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            sw_db <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= sw_raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == sw_db) begin
                // Any agreeing cycle throws away partial progress
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                sw_db <= s2;
                cnt   <= '0;
                rise  <= s2;
                fall  <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Bits are fully independent; one conditioner per switch
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .sw_raw  (sw_raw[i]),
            .sw_db   (sw_db[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // Single OR level after the pulse registers
    always_comb begin
        changed = |{rise, fall};
    end

endmodule
